pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and halt-drain controller for the N-stage in-order integer pipeline.
- Holds a scoreboard of in-flight destination writes for stages EX..WB.
- Drives operand-forward selects for the ID stage, load-use stall/bubble, branch/jump flush, and a halt drain FSM.
- Replaces the fixed 5-stage forwarding and hazard units with one block that scales with pipeline depth and load latency.

Parameters:
- NUM_STAGES, 5, total pipeline stages IF..WB; scoreboard depth D = NUM_STAGES-2 (index 0 = EX … D-1 = WB); legal range 4..8.
- REG_AW, 4, register address width.
- LOAD_LAT, 1, first scoreboard index at which load data is forwardable; legal range 0..D-1.
- REG0_ZERO, 1, when 1 register 0 never creates a dependency or forward.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_src0_addr  in  REG_AW  ID source 0 register.
- id_src0_used  in  1  source 0 is read.
- id_src1_addr  in  REG_AW  ID source 1 register.
- id_src1_used  in  1  source 1 is read.
- id_we  in  1  ID instruction writes the register file.
- id_dst_addr  in  REG_AW  ID destination register.
- id_is_load  in  1  ID instruction is a load.
- id_is_hlt  in  1  ID instruction is HLT.
- id_jump  in  1  jump resolved in ID, redirect requested.
- ex_branch_taken  in  1  taken branch resolved in EX.
- ex_we_cancel  in  1  EX instruction suppresses its write (conditional add with Z=0); clears we of scoreboard entry 0 for this cycle and when it shifts.
- stall_fetch  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  IF/ID loads a bubble next edge.
- bubble_ex  out  1  ID/EX loads a bubble next edge.
- jump_ok  out  1  id_jump accepted this cycle; PC takes the jump target.
- fwd_sel0  out  D  one-hot forward source for src0; bit i = scoreboard stage i; 0 = register file.
- fwd_sel1  out  D  same, for src1.
- draining  out  1  HLT in flight, front end frozen.
- hlt  out  1  HLT reached WB; sticky.

Behaviour:
- Scoreboard: D entries of {v, we, dst, ld, hlt}. Each edge entry i moves to i+1 and entry D-1 retires. Entry 0 takes the ID instruction when ID advances (id_valid & ~stall_id & ~ex_branch_taken & ~draining); otherwise entry 0 takes a bubble (v=0).
- Match rule: entry i matches src s when v & we & dst==addr_s & src_used_s, excluding dst==0 when REG0_ZERO=1.
- Only the lowest matching index (youngest) counts.
- Forwarding: fwd_selN bit i set for the youngest match if (~ld | i>=LOAD_LAT); otherwise all zero. Combinational.
- Load-use: youngest match with ld & i<LOAD_LAT for either source -> luse=1.
- Priority, highest first:
  - ex_branch_taken: flush_id=1, bubble_ex=1, stall_*=0, jump_ok=0.
  - luse & id_valid: stall_fetch=stall_id=1, bubble_ex=1, jump_ok=0. A jump waits while stalled.
  - id_jump & id_valid: jump_ok=1, flush_id=1.
  - Otherwise all zero.
- Halt FSM states:
  - RUN: HLT accepted into entry 0 (not flushed, not stalled) -> DRAIN.
  - DRAIN: draining=1, stall_fetch=stall_id=1, flush_id=0, bubble_ex=1 (no new entries). When the hlt entry retires from D-1 -> HALTED.
  - HALTED: hlt=1, draining=1, outputs frozen, scoreboard empty; left only by rst.
- A HLT in ID while a taken branch is in EX is flushed and never enters DRAIN.
- Reset: all entries v=0; state RUN; all outputs 0. Synchronous rst mid-operation clears everything on that edge, including HALTED.
- Latency: forward/stall outputs are combinational from inputs and current scoreboard. hlt rises D cycles after HLT leaves ID.

Test Plan:
- Back-to-back ALU dependency: ADD r3 then SUB r4,r3 with defaults -> fwd_sel0=3'b001 in second cycle, no stall.
- Load-use: LW r5 then ADD r6,r5, LOAD_LAT=1 -> one cycle stall_id=stall_fetch=bubble_ex=1, then fwd_sel0=3'b010. With LOAD_LAT=0 -> no stall, fwd_sel0=3'b001.
- Youngest wins: writes to r2 in WB and EX -> fwd_sel=3'b001. Src r0 with REG0_ZERO=1 -> fwd_sel=0.
- Branch vs stalled jump: ex_branch_taken with a load-use stall pending -> flush_id=1, bubble_ex=1, stall=0. Jump stalled by load-use -> jump_ok=0 that cycle, 1 the next.
- Halt drain, NUM_STAGES=5: HLT accepted at cycle t -> draining=1 from t+1, hlt=1 at t+3 and stays 1. HLT in ID with ex_branch_taken -> never drains.
- rst asserted in DRAIN and in HALTED -> next cycle all outputs 0, state RUN. ex_we_cancel on conditional add -> consumer's fwd_sel=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt-drain control for an in-order pipeline. Forward selects
// and stalls are combinational from ID inputs and the scoreboard. ID is held on load-use or drain.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 4,
  parameter int LOAD_LAT   = 1,
  parameter bit REG0_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_src0_addr,
  input  logic                  id_src0_used,
  input  logic [REG_AW-1:0]     id_src1_addr,
  input  logic                  id_src1_used,
  input  logic                  id_we,
  input  logic [REG_AW-1:0]     id_dst_addr,
  input  logic                  id_is_load,
  input  logic                  id_is_hlt,
  input  logic                  id_jump,
  input  logic                  ex_branch_taken,
  input  logic                  ex_we_cancel,
  output logic                  stall_fetch,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  bubble_ex,
  output logic                  jump_ok,
  output logic [NUM_STAGES-3:0] fwd_sel0,
  output logic [NUM_STAGES-3:0] fwd_sel1,
  output logic                  draining,
  output logic                  hlt
);
  localparam int D = NUM_STAGES - 2;

  typedef struct packed {
    logic              v;
    logic              we;
    logic [REG_AW-1:0] dst;
    logic              ld;
    logic              hlt;
  } sb_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state_q;
  logic   draining_q;
  logic   hlt_q;
  sb_t    sb_q   [D];
  sb_t    sb_eff [D];
  sb_t    id_entry;
  logic   luse0, luse1, luse, advance;

  function automatic logic src_match(sb_t e, logic [REG_AW-1:0] a, logic used);
    src_match = e.v && e.we && used && (e.dst == a) && !(REG0_ZERO && (e.dst == '0));
  endfunction

  // A cancelled conditional write must neither forward now nor once it moves down the pipe.
  always_comb begin
    for (int i = 0; i < D; i++) sb_eff[i] = sb_q[i];
    sb_eff[0].we = sb_q[0].we & ~ex_we_cancel;
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_sel0 = '0;
    fwd_sel1 = '0;
    luse0    = 1'b0;
    luse1    = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      if (src_match(sb_eff[i], id_src0_addr, id_src0_used)) begin
        fwd_sel0    = '0;
        luse0       = sb_eff[i].ld && (i < LOAD_LAT);
        fwd_sel0[i] = !luse0;
      end
      if (src_match(sb_eff[i], id_src1_addr, id_src1_used)) begin
        fwd_sel1    = '0;
        luse1       = sb_eff[i].ld && (i < LOAD_LAT);
        fwd_sel1[i] = !luse1;
      end
    end
  end

  assign luse = luse0 | luse1;

  always_comb begin
    stall_fetch = 1'b0;
    stall_id    = 1'b0;
    flush_id    = 1'b0;
    bubble_ex   = 1'b0;
    jump_ok     = 1'b0;
    if (state_q != RUN) begin
      stall_fetch = 1'b1;
      stall_id    = 1'b1;
      bubble_ex   = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (luse && id_valid) begin
      stall_fetch = 1'b1;
      stall_id    = 1'b1;
      bubble_ex   = 1'b1;
    end else if (id_jump && id_valid) begin
      jump_ok  = 1'b1;
      flush_id = 1'b1;
    end
  end

  assign advance  = id_valid && !stall_id && !ex_branch_taken && (state_q == RUN);
  assign draining = draining_q;
  assign hlt      = hlt_q;

  always_comb begin
    id_entry     = '0;
    id_entry.v   = 1'b1;
    id_entry.we  = id_we;
    id_entry.dst = id_dst_addr;
    id_entry.ld  = id_is_load;
    id_entry.hlt = id_is_hlt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      draining_q <= 1'b0;
      hlt_q      <= 1'b0;
      for (int i = 0; i < D; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= advance ? id_entry : '0;
      for (int i = 1; i < D; i++) sb_q[i] <= sb_eff[i-1];
      case (state_q)
        RUN: begin
          if (advance && id_is_hlt) begin
            state_q    <= DRAIN;
            draining_q <= 1'b1;
          end
        end
        DRAIN: begin
          // hlt goes high as the HLT entry lands in WB; state follows once it retires.
          if (sb_q[D-2].v && sb_q[D-2].hlt) hlt_q <= 1'b1;
          if (sb_q[D-1].v && sb_q[D-1].hlt) state_q <= HALTED;
        end
        default: begin
        end
      endcase
    end
  end
endmodule
